uni_shifter_n: RTL
==================

# uni_shifter_n

Parametrised universal shift register, W bits wide. It succeeds the fixed 8-bit load/shift-left/shift-right/hold register. It adds asynchronous active-low reset, rotate, arithmetic-shift-right and clear modes, a registered serial-out bit, and a multi-step command: one start request performs `amt` shift or rotate steps, one step per clock, with a busy/done handshake. It sits in the datapath wherever a bit-serial or barrel-free shift of a data word is needed, for example serial links and shift-and-add multipliers.

## Interface
- W, default 8: register width, 2 or more.
- AW, default $clog2(W)+1: width of `amt`. Derived; do not override.
- c  input  1  clock; all state changes on the rising edge.
- nrst  input  1  reset; asynchronous assert, synchronous release, active-low.
- d  input  W  parallel load data.
- i  input  1  serial input bit, shifted in on shift steps.
- op  input  3  operation code (see Operation).
- en  input  1  single-step enable; applies `op` once per edge.
- start  input  1  multi-step command request.
- amt  input  AW  step count for `start`.
- q  output  W  register contents.
- so  output  1  registered serial-out: the bit that left the register on the last shift or rotate step.
- busy  output  1  multi-step command in progress.
- done  output  1  one-cycle pulse when a `start` command completes.

## Operation
- Op codes:
  - 000 hold.
  - 001 load: q<=d.
  - 010 SHL: q<={q[W-2:0],i}; so<=q[W-1].
  - 011 SHR: q<={i,q[W-1:1]}; so<=q[0].
  - 100 ROL: q<={q[W-2:0],q[W-1]}; so<=q[W-1].
  - 101 ROR: q<={q[0],q[W-1:1]}; so<=q[0].
  - 110 ASR: q<={q[W-1],q[W-1:1]}; so<=q[0].
  - 111 clear: q<=0.
- `so` changes only on shift, rotate or ASR steps. Hold, load and clear leave `so` unchanged.
- Two states, IDLE and RUN. The latched op and the step counter (AW bits) are internal registers.
- IDLE, start=1:
  - Latch op and amt; start wins over en.
  - If op is a step op (010..110) and amt≠0: go to RUN, counter<=amt, busy<=1. q is not modified on this edge.
  - If op is a step op and amt=0: stay IDLE, q unchanged, done<=1.
  - If op is non-step (000, 001, 111): execute op on this edge, stay IDLE, done<=1; amt is ignored.
- IDLE, start=0, en=1: execute op on this edge.
- IDLE, start=0, en=0: hold.
- RUN: on each edge, perform one step of the latched op, sampling `i` at that edge, and decrement the counter.
  - The step that brings the counter to 0 also sets busy<=0 and done<=1, and the state returns to IDLE.
- RUN ignores start, en, op and amt. A start presented while busy=1 is dropped, not queued.
- Any amt value up to 2^AW−1 is legal and performs exactly amt steps. SHL or SHR with amt≥W leaves q equal to the last W serial inputs. Rotates with amt=W return q to its original value.
- Reset, nrst=0, at any time including mid-RUN:
  - q=0, so=0, busy=0, done=0, state IDLE, counter=0, latched op=000.
  - An interrupted command produces no done.

## Timing
- Single-step (en) latency: q updates on the edge at which en=1 is sampled.
- Multi-step:
  - Start is sampled on edge E0.
  - busy is high from E0 through E_amt, where E_k is the k-th edge after E0.
  - The step k result is visible after E_k.
  - done is high for the single cycle following E_amt, the same edge at which busy falls.
- A new start is accepted on the edge where done=1 is being output, which gives back-to-back commands with no idle gap.
- Zero-step or non-step start: done is high for the one cycle after E0, and busy never rises.
- done is never high for more than one consecutive cycle unless back-to-back commands complete on consecutive edges.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset mid-command: W=8; load d=8'hA5; start ROL amt=5; drop nrst after 2 steps -> q=0, so=0, busy=0, no done. After release, en with op=001 and d=8'h3C -> q=8'h3C in 1 edge.
- Multi-step rotate: W=8, q=8'h81; start ROL amt=3 -> busy high for 3 edges, q sequence 03, 06, 0C, so sequence 1, 0, 0, done pulses once. Then start ROR amt=8 -> q=8'h0C after 8 steps.
- Shift with serial in: W=8, q=8'hFF; start SHR amt=4 with i=0,1,0,1 on successive step edges -> q=8'hAF, so=1.
- ASR and overlong shift: W=8, q=8'h90; start ASR amt=3 -> q=8'hF2. Then start SHL amt=9 with i=1 throughout -> q=8'hFF; the start presented during busy is ignored.
- Zero/non-step and en: start SHL amt=0 -> done for 1 cycle, q unchanged, busy stays 0. start with op=111 -> q=0 and done next cycle. en=1 with op=010, i=1, for 3 edges from q=0 -> q=8'h07. start and en both high -> only the start command executes.
- Parameter sweep: W=2, 5, 16 → run ROL for W steps and SHR for 2W−1 steps from a random q; check against the reference model, including done timing, the busy cycle count, and `so` after every step.

Source files
------------

// File: rtl/uni_shifter_n_if.sv
// Control, data and status bundle for uni_shifter_n.
// The master drives the command side; the shifter is the slave.
interface uni_shifter_n_if #(
    parameter int W  = 8,
    parameter int AW = $clog2(W) + 1
);
    logic [W-1:0]  d;
    logic          i;
    logic [2:0]    op;
    logic          en;
    logic          start;
    logic [AW-1:0] amt;
    logic [W-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;

    modport master (output d, i, op, en, start, amt, input  q, so, busy, done);
    modport slave  (input  d, i, op, en, start, amt, output q, so, busy, done);
endinterface

// File: rtl/uni_shifter_n.sv
// W-bit universal shift register: en applies op on the sampling edge; start runs amt steps, one per edge.
// busy is high while a command runs and any start seen then is dropped; done pulses one cycle at completion.
module uni_shifter_n #(
    parameter int W  = 8,
    parameter int AW = $clog2(W) + 1
) (
    input  logic           c,
    input  logic           nrst,
    uni_shifter_n_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [2:0]    lop, lop_nxt;
    logic [W-1:0]  q_r, q_nxt;
    logic          so_r, so_nxt;
    logic          busy_r;
    logic          done_r, done_nxt;
    logic [2:0]    xop;
    logic          xen;
    logic          is_step;

    assign is_step = (bus.op >= OP_SHL) && (bus.op <= OP_ASR);

    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            lop    <= OP_HOLD;
            q_r    <= '0;
            so_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            lop    <= lop_nxt;
            q_r    <= q_nxt;
            so_r   <= so_nxt;
            busy_r <= (state_nxt == RUN);
            done_r <= done_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        cnt_nxt   = cnt;
        lop_nxt   = lop;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    lop_nxt = bus.op;
                    cnt_nxt = bus.amt;
                    // Zero-length and non-step commands complete on the accepting edge.
                    if (is_step && (bus.amt != '0)) state_nxt = RUN;
                    else                            done_nxt  = 1'b1;
                end
            end
            RUN: begin
                cnt_nxt = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin : datapath
        xop = lop;
        xen = 1'b0;
        if (state == RUN) begin
            xen = 1'b1;
        end else if (bus.start) begin
            // A step-op start only arms the command; q moves from the next edge.
            xop = bus.op;
            xen = !is_step;
        end else if (bus.en) begin
            xop = bus.op;
            xen = 1'b1;
        end

        q_nxt  = q_r;
        so_nxt = so_r;
        if (xen) begin
            case (xop)
                OP_LOAD: q_nxt = bus.d;
                OP_SHL: begin
                    q_nxt  = {q_r[W-2:0], bus.i};
                    so_nxt = q_r[W-1];
                end
                OP_SHR: begin
                    q_nxt  = {bus.i, q_r[W-1:1]};
                    so_nxt = q_r[0];
                end
                OP_ROL: begin
                    q_nxt  = {q_r[W-2:0], q_r[W-1]};
                    so_nxt = q_r[W-1];
                end
                OP_ROR: begin
                    q_nxt  = {q_r[0], q_r[W-1:1]};
                    so_nxt = q_r[0];
                end
                OP_ASR: begin
                    q_nxt  = {q_r[W-1], q_r[W-1:1]};
                    so_nxt = q_r[0];
                end
                OP_CLR:  q_nxt = '0;
                default: q_nxt = q_r;
            endcase
        end
    end

    assign bus.q    = q_r;
    assign bus.so   = so_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule
